// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: switch/key inputs and captured ALU operand outputs
interface alu_operand_loader_if;
  logic [5:0] sw_i;
  logic       key_i;
  logic [5:0] A_o;
  logic [5:0] B_o;
  logic [1:0] Op_o;
  logic       valid_o;
  logic [1:0] state_o;
  modport master (output sw_i, key_i, input A_o, B_o, Op_o, valid_o, state_o);
  modport slave (input sw_i, key_i, output A_o, B_o, Op_o, valid_o, state_o);
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures A, B and opcode from switches on key presses (debounce enabled by ALU_LOADER_DEBOUNCE_EN)
module alu_operand_loader #(
  parameter int DEB_CYCLES = 50000
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  alu_operand_loader_if.slave bus
);
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_DONE = 2'b11} state_t;
  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("DEB_CYCLES out of range 2..65535");
  end
  logic [5:0] sw_m, sw_s;
  logic       key_m, key_s, deb, deb_q, press;
  state_t     state, state_nx;
  logic [5:0] a_q, a_nx, b_q, b_nx;
  logic [1:0] op_q, op_nx;
  logic       valid_q, valid_nx;
  // two-flop synchronizers for the asynchronous switches and key
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      sw_m  <= '0;
      sw_s  <= '0;
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sw_m  <= bus.sw_i;
      sw_s  <= sw_m;
      key_m <= bus.key_i;
      key_s <= key_m;
    end
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam logic [15:0] CNT_MAX = 16'(DEB_CYCLES - 1);
  logic [15:0] cnt;
  // debounced level follows the key only after it has stayed changed for DEB_CYCLES clocks
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (key_s == deb)
      cnt <= '0;
    else if (cnt == CNT_MAX) begin
      deb <= key_s;
      cnt <= '0;
    end else
      cnt <= cnt + 16'd1;
`else
  assign deb = key_s;
`endif
  // registered falling-edge detect gives one press pulse per key-down
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      deb_q <= 1'b1;
      press <= 1'b0;
    end else begin
      deb_q <= deb;
      press <= deb_q & ~deb;
    end
  // entry step and captured fields
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state   <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      a_q     <= a_nx;
      b_q     <= b_nx;
      op_q    <= op_nx;
      valid_q <= valid_nx;
    end
  // each press writes the field for the current step and advances; DONE wraps to A
  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    op_nx    = op_q;
    valid_nx = valid_q;
    if (press) begin
      state_nx = state_t'(state + 2'd1);
      a_nx     = state == S_A ? sw_s : a_q;
      b_nx     = state == S_B ? sw_s : b_q;
      op_nx    = state == S_OP ? sw_s[1:0] : op_q;
      valid_nx = state == S_OP;
    end
  end
  assign bus.A_o     = a_q;
  assign bus.B_o     = b_q;
  assign bus.Op_o    = op_q;
  assign bus.valid_o = valid_q;
  assign bus.state_o = state;
endmodule
